// File: rtl/soft_dist_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soft_dist_pkg : shared encodings and saturating helpers for soft_distortion_stereo
// Rev 1.0
// ----------------------------------------------------------------------------
package soft_dist_pkg;

  localparam logic [1:0] MODE_SOFT = 2'b00;
  localparam logic [1:0] MODE_HARD = 2'b01;

  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } gate_state_t;

  // Helpers work on a 64-bit sign-extended carrier; w is the real sample width (w <= 56).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_abs(input logic [63:0] x, input int w);
    logic [63:0] a;
    a = x[63] ? (~x + 64'd1) : x;
    return (a > sat_max(w)) ? sat_max(w) : a;
  endfunction

  function automatic logic [63:0] sat_shift(input logic [63:0] m, input logic [2:0] sh,
                                            input int w);
    logic [63:0] s;
    s = m << sh;
    return (s > sat_max(w)) ? sat_max(w) : s;
  endfunction

  // Concave soft-clip curve: 0 at index 0, knee (max-1) from mid-scale, max at the last entry.
  function automatic int lut_entry(input int i, input int idx_w, input int lut_w);
    int half;
    int top;
    int knee;
    int d;
    half = 1 << (idx_w - 1);
    top  = (1 << lut_w) - 1;
    knee = top - 1;
    if (i >= (1 << idx_w) - 1) return top;
    if (i >= half) return knee;
    d = half - i;
    return knee - (knee * d * d) / (half * half);
  endfunction

endpackage
`default_nettype wire

// File: rtl/soft_distortion_stereo_dist_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dist_channel : per-channel S2/S3 datapath (drive, soft LUT / hard clip, sign restore)
// Rev 1.0
// ----------------------------------------------------------------------------
module dist_channel
  import soft_dist_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                IDX_W      = 8,
  parameter int                LUT_W      = 8,
  parameter logic [DATA_W-1:0] CLIP_LEVEL = {2'b01, {(DATA_W-2){1'b0}}}
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              advance,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] mag,
  input  logic              enable,
  input  logic              hard,
  input  logic              pass,
  input  logic [2:0]        drive,
  output logic [DATA_W-1:0] result
);

  logic [LUT_W-1:0] lut [2**IDX_W];

  for (genvar g = 0; g < 2**IDX_W; g++) begin : g_lut
    assign lut[g] = LUT_W'(lut_entry(g, IDX_W, LUT_W));
  end

  logic [DATA_W-1:0] mag_d;
  logic [IDX_W-1:0]  idx;

  assign mag_d = DATA_W'(sat_shift(64'(mag), drive, DATA_W));
  assign idx   = mag_d[DATA_W-2 -: IDX_W];

  logic [LUT_W-1:0]  lut_q;
  logic [DATA_W-1:0] clip_q;
  logic [DATA_W-1:0] raw_q;
  logic              en_q;
  logic              hard_q;
  logic              pass_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lut_q  <= '0;
      clip_q <= '0;
      raw_q  <= '0;
      en_q   <= 1'b0;
      hard_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (advance) begin
      lut_q  <= lut[idx];
      clip_q <= (mag_d > CLIP_LEVEL) ? CLIP_LEVEL : mag_d;
      raw_q  <= sample;
      en_q   <= enable;
      hard_q <= hard;
      pass_q <= pass;
    end
  end

  logic [DATA_W-1:0] mag_o;
  logic [DATA_W-1:0] signed_o;
  logic [DATA_W-1:0] next_o;

  always_comb begin
    mag_o    = hard_q ? clip_q : (DATA_W'(lut_q) << (DATA_W - 1 - LUT_W));
    signed_o = raw_q[DATA_W-1] ? (~mag_o + DATA_W'(1)) : mag_o;
    next_o   = '0;
    if (pass_q) next_o = en_q ? signed_o : raw_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      result <= '0;
    else if (advance) result <= next_o;
  end

endmodule
`default_nettype wire

// File: rtl/soft_distortion_stereo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// soft_distortion_stereo : 3-stage stereo distortion with shared hysteresis noise gate
// Rev 1.0
// ----------------------------------------------------------------------------
module soft_distortion_stereo
  import soft_dist_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                IDX_W        = 8,
  parameter int                LUT_W        = 8,
  parameter int                GATE_OPEN    = 5_000_000,
  parameter int                GATE_CLOSE   = 3_000_000,
  parameter int                HOLD_SAMPLES = 480,
  parameter logic [DATA_W-1:0] CLIP_LEVEL   = {2'b01, {(DATA_W-2){1'b0}}}
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [2:0]        drive,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              gate_open
);

  localparam int                CNT_W    = $clog2(HOLD_SAMPLES + 1);
  localparam logic [DATA_W-1:0] OPEN_TH  = DATA_W'(GATE_OPEN);
  localparam logic [DATA_W-1:0] CLOSE_TH = DATA_W'(GATE_CLOSE);

  logic advance;
  logic accept;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  logic [DATA_W-1:0] abs_l;
  logic [DATA_W-1:0] abs_r;
  logic [DATA_W-1:0] mag;

  assign abs_l = DATA_W'(sat_abs(64'(signed'(left_in)), DATA_W));
  assign abs_r = DATA_W'(sat_abs(64'(signed'(right_in)), DATA_W));
  assign mag   = (abs_l > abs_r) ? abs_l : abs_r;

  gate_state_t      state_q;
  gate_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      unique case (state_q)
        CLOSED: if (mag >= OPEN_TH) state_d = OPEN;
        OPEN: begin
          if (mag < CLOSE_TH) begin
            state_d = HOLD;
            cnt_d   = CNT_W'(HOLD_SAMPLES - 1);
          end
        end
        HOLD: begin
          if (mag >= OPEN_TH)     state_d = OPEN;
          else if (cnt_q == '0)   state_d = CLOSED;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = CLOSED;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gate_open = (state_q != CLOSED);

  logic              s1_valid;
  logic              s2_valid;
  logic              s3_valid;
  logic [DATA_W-1:0] s1_left;
  logic [DATA_W-1:0] s1_right;
  logic [DATA_W-1:0] s1_mag_l;
  logic [DATA_W-1:0] s1_mag_r;
  logic              s1_en;
  logic              s1_hard;
  logic              s1_pass;
  logic [2:0]        s1_drive;

  // The gate tag is the post-update state so the pair that opens the gate is itself passed.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_left  <= '0;
      s1_right <= '0;
      s1_mag_l <= '0;
      s1_mag_r <= '0;
      s1_en    <= 1'b0;
      s1_hard  <= 1'b0;
      s1_pass  <= 1'b0;
      s1_drive <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      s1_left  <= left_in;
      s1_right <= right_in;
      s1_mag_l <= abs_l;
      s1_mag_r <= abs_r;
      s1_en    <= enable;
      s1_hard  <= (mode == MODE_HARD);
      s1_pass  <= (state_d != CLOSED);
      s1_drive <= drive;
    end
  end

  assign out_valid = s3_valid;

  dist_channel #(
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W),
    .LUT_W      (LUT_W),
    .CLIP_LEVEL (CLIP_LEVEL)
  ) u_left (
    .clk     (CLOCK_50),
    .resetn  (resetn),
    .advance (advance),
    .sample  (s1_left),
    .mag     (s1_mag_l),
    .enable  (s1_en),
    .hard    (s1_hard),
    .pass    (s1_pass),
    .drive   (s1_drive),
    .result  (left_out)
  );

  dist_channel #(
    .DATA_W     (DATA_W),
    .IDX_W      (IDX_W),
    .LUT_W      (LUT_W),
    .CLIP_LEVEL (CLIP_LEVEL)
  ) u_right (
    .clk     (CLOCK_50),
    .resetn  (resetn),
    .advance (advance),
    .sample  (s1_right),
    .mag     (s1_mag_r),
    .enable  (s1_en),
    .hard    (s1_hard),
    .pass    (s1_pass),
    .drive   (s1_drive),
    .result  (right_out)
  );

endmodule
`default_nettype wire
